// File: rtl/mem_port_arbiter_if.sv
// Request/grant/return bundle between the fetch port, the data port and the
// shared single-port memory. The arbiter takes the slave view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_stall;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_stall;

    logic              mem_cs;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, if_stall,
        output d_gnt, d_rvalid, d_rdata, d_stall,
        output mem_cs, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, if_stall,
        input  d_gnt, d_rvalid, d_rdata, d_stall,
        input  mem_cs, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Data has priority; a starvation counter forces a fetch grant periodically.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [2:0] LAT_LAST   = 3'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state;
    logic [2:0]        lat_cnt;
    logic              owner;
    logic [3:0]        starve_cnt;

    logic              ret_cyc;
    logic              free;
    logic              pick_if;
    logic              if_gnt;
    logic              d_gnt;
    logic              rd_issue;
    logic              if_rvalid;
    logic              d_rvalid;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // The return cycle is also an arbitration slot so reads can go back to back.
    always_comb begin
        ret_cyc   = (state == BUSY) && (lat_cnt == LAT_LAST);
        free      = (state == IDLE) || ret_cyc;
        pick_if   = bus.if_req && (!bus.d_req || (starve_cnt == STARVE_LIM));
        if_gnt    = !rst && free && pick_if;
        d_gnt     = !rst && free && bus.d_req && !pick_if;
        rd_issue  = if_gnt || (d_gnt && !bus.d_we);
        if_rvalid = !rst && ret_cyc && !owner;
        d_rvalid  = !rst && ret_cyc && owner;
        sel_addr  = '0;
        sel_wdata = '0;
        if (d_gnt) begin
            sel_addr  = bus.d_addr;
            sel_wdata = bus.d_wdata;
        end else if (if_gnt) begin
            sel_addr = bus.if_addr;
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.if_rvalid = if_rvalid;
    assign bus.d_rvalid  = d_rvalid;
    assign bus.if_rdata  = if_rvalid ? bus.mem_rdata : '0;
    assign bus.d_rdata   = d_rvalid ? bus.mem_rdata : '0;
    assign bus.mem_cs    = if_gnt || d_gnt;
    assign bus.mem_we    = d_gnt && bus.d_we;
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = sel_wdata;

    // Stall covers both "not yet granted" and "read in flight, data not back".
    assign bus.if_stall = !rst && ((bus.if_req && !if_gnt) ||
                                   ((state == BUSY) && !ret_cyc && !owner));
    assign bus.d_stall  = !rst && ((bus.d_req && !d_gnt) ||
                                   ((state == BUSY) && !ret_cyc && owner));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            owner      <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if (free) begin
                state   <= rd_issue ? BUSY : IDLE;
                lat_cnt <= '0;
                if (rd_issue) begin
                    owner <= d_gnt;
                end
            end else begin
                lat_cnt <= lat_cnt + 3'd1;
            end

            if (!bus.if_req || if_gnt) begin
                starve_cnt <= '0;
            end else if (d_gnt && (starve_cnt != STARVE_LIM)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT 1, 2, 3) share one
// stimulus; directed vectors, corner sequences and a random reference-model run.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] mem_rdata;

    // flags: {if_gnt, d_gnt, if_rvalid, d_rvalid, if_stall, d_stall, mem_cs, mem_we}
    logic [2:0][7:0]  o_flags;
    logic [2:0][31:0] o_addr;
    logic [2:0][31:0] o_wdata;
    logic [2:0][31:0] o_ird;
    logic [2:0][31:0] o_drd;
    logic [3:0]       starve0;

    int n_checks = 0;
    int n_err    = 0;

    for (genvar g = 0; g < 3; g++) begin : lane
        mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

        mem_port_arbiter #(
            .ADDR_W(32), .DATA_W(32), .MEM_LAT(g + 1), .STARVE_MAX(3)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );

        assign bus.if_req    = if_req;
        assign bus.if_addr   = if_addr;
        assign bus.d_req     = d_req;
        assign bus.d_we      = d_we;
        assign bus.d_addr    = d_addr;
        assign bus.d_wdata   = d_wdata;
        assign bus.mem_rdata = mem_rdata;

        assign o_flags[g] = {bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid,
                             bus.if_stall, bus.d_stall, bus.mem_cs, bus.mem_we};
        assign o_addr[g]  = bus.mem_addr;
        assign o_wdata[g] = bus.mem_wdata;
        assign o_ird[g]   = bus.if_rdata;
        assign o_drd[g]   = bus.d_rdata;
    end

    assign starve0 = lane[0].u_dut.starve_cnt;

    typedef struct {
        logic        rst;
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [31:0] mem_rdata;
        logic [7:0]  fl;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] ird;
        logic [31:0] drd;
    } vec_t;

    vec_t tbl[11];

    // Reference model: an outstanding read is remembered by the cycle it returns on.
    bit m_busy[3];
    int m_due[3];
    bit m_owner[3];
    int m_starve[3];

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic drive(input logic r, input logic ir, input logic [31:0] ia,
                         input logic dr, input logic dw, input logic [31:0] da,
                         input logic [31:0] dwd, input logic [31:0] mrd);
        @(negedge clk);
        rst       = r;
        if_req    = ir;
        if_addr   = ia;
        d_req     = dr;
        d_we      = dw;
        d_addr    = da;
        d_wdata   = dwd;
        mem_rdata = mrd;
        #1;
    endtask

    task automatic expect_lane(input string name, input int l, input logic [7:0] fl,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] ird, input logic [31:0] drd);
        check(name, {24'd0, o_flags[l], o_addr[l], o_wdata[l], o_ird[l], o_drd[l]},
                    {24'd0, fl, addr, wd, ird, drd});
    endtask

    task automatic model_check(input int l, input int c);
        bit ret, free, pick_i, gi, gd, si, sd;
        logic [7:0]  fl;
        logic [31:0] ea, ew, eir, edr;
        ret    = m_busy[l] && (m_due[l] == c);
        free   = !m_busy[l] || ret;
        pick_i = if_req && (!d_req || (m_starve[l] == 3));
        gi     = !rst && free && pick_i;
        gd     = !rst && free && d_req && !pick_i;
        si     = (if_req && !gi) || (m_busy[l] && !ret && !m_owner[l]);
        sd     = (d_req && !gd) || (m_busy[l] && !ret && m_owner[l]);
        if (rst) begin
            fl = '0; ea = '0; ew = '0; eir = '0; edr = '0;
        end else begin
            fl  = {gi, gd, ret && !m_owner[l], ret && m_owner[l], si, sd, gi || gd, gd && d_we};
            ea  = gd ? d_addr : (gi ? if_addr : 32'd0);
            ew  = gd ? d_wdata : 32'd0;
            eir = (ret && !m_owner[l]) ? mem_rdata : 32'd0;
            edr = (ret && m_owner[l]) ? mem_rdata : 32'd0;
        end
        expect_lane($sformatf("rand c%0d lane%0d", c, l), l, fl, ea, ew, eir, edr);

        if (rst) begin
            m_busy[l]   = 0;
            m_starve[l] = 0;
        end else begin
            if (free) begin
                if (gi || (gd && !d_we)) begin
                    m_busy[l]  = 1;
                    m_due[l]   = c + l + 1;
                    m_owner[l] = gd;
                end else begin
                    m_busy[l] = 0;
                end
            end
            if (!if_req || gi) m_starve[l] = 0;
            else if (gd && m_starve[l] < 3) m_starve[l]++;
        end
    endtask

    initial begin
        rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0;
        d_addr = 0; d_wdata = 0; mem_rdata = 0;

        // Directed vectors on the MEM_LAT=1 instance.
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 8'b0000_0000, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_0000, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 32'h40, 0, 0, 0, 0, 0, 8'b1000_0010, 32'h40, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 32'h8C220000, 8'b0010_0000, 0, 0, 32'h8C220000, 0};
        tbl[4]  = '{0, 1, 32'h44, 1, 1, 32'h100, 32'hDEADBEEF, 0, 8'b0100_1011, 32'h100, 32'hDEADBEEF, 0, 0};
        tbl[5]  = '{0, 1, 32'h44, 0, 0, 0, 0, 0, 8'b1000_0010, 32'h44, 0, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 32'h12345678, 8'b0010_0000, 0, 0, 32'h12345678, 0};
        tbl[7]  = '{0, 0, 0, 1, 0, 32'h200, 0, 0, 8'b0100_0010, 32'h200, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 32'hCAFEF00D, 8'b0001_0000, 0, 0, 0, 32'hCAFEF00D};
        tbl[9]  = '{0, 0, 0, 1, 1, 32'h300, 32'h1, 32'hFFFFFFFF, 8'b0100_0011, 32'h300, 32'h1, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 32'hAAAA5555, 8'b0000_0000, 0, 0, 0, 0};

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].if_req, tbl[i].if_addr, tbl[i].d_req, tbl[i].d_we,
                  tbl[i].d_addr, tbl[i].d_wdata, tbl[i].mem_rdata);
            expect_lane($sformatf("tbl row%0d", i), 0, tbl[i].fl, tbl[i].addr,
                        tbl[i].wd, tbl[i].ird, tbl[i].drd);
        end

        // Starvation: both ports request reads every cycle, MEM_LAT=1.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            drive(0, 1, 32'h1000, 1, 0, 32'h2000, 0, 32'h0);
            check($sformatf("starve cnt k%0d", k), {156'd0, starve0}, 160'(k % 4));
            check($sformatf("starve gnt k%0d", k), {158'd0, o_flags[0][7:6]},
                  (k % 4 == 3) ? 160'b10 : 160'b01);
        end

        // Reset while a MEM_LAT=2 data read is in flight.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 32'h80, 0, 0);
        expect_lane("rstmid grant", 1, 8'b0100_0010, 32'h80, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        expect_lane("rstmid rst cycle", 1, 8'b0000_0000, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 32'h55AA55AA);
        expect_lane("rstmid after", 1, 8'b0000_0000, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 32'h55AA55AA);
        expect_lane("rstmid after2", 1, 8'b0000_0000, 0, 0, 0, 0);

        // Back-to-back reads on the MEM_LAT=3 instance.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 32'h20, 1, 0, 32'h10, 0, 0);
        expect_lane("b2b N", 2, 8'b0100_1010, 32'h10, 0, 0, 0);
        drive(0, 1, 32'h20, 0, 0, 0, 0, 0);
        expect_lane("b2b N+1", 2, 8'b0000_1100, 0, 0, 0, 0);
        drive(0, 1, 32'h20, 0, 0, 0, 0, 0);
        expect_lane("b2b N+2", 2, 8'b0000_1100, 0, 0, 0, 0);
        drive(0, 1, 32'h20, 0, 0, 0, 0, 32'h0000D00D);
        expect_lane("b2b N+3", 2, 8'b1001_0010, 32'h20, 0, 0, 32'h0000D00D);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        expect_lane("b2b N+4", 2, 8'b0000_1000, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        expect_lane("b2b N+5", 2, 8'b0000_1000, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 32'h00001F1F);
        expect_lane("b2b N+6", 2, 8'b0010_0000, 0, 0, 32'h00001F1F, 0);

        // Idle: nothing requested for 10 cycles.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, $urandom);
            check($sformatf("idle flags k%0d", k), {136'd0, o_flags}, 160'd0);
            check($sformatf("idle starve k%0d", k), {156'd0, starve0}, 160'd0);
        end

        // Random traffic against the reference model, all three instances.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            rst       = (c == 0) || ($urandom_range(0, 99) < 3);
            if_req    = $urandom_range(0, 9) < 7;
            if_addr   = $urandom;
            d_req     = $urandom_range(0, 9) < 7;
            d_we      = $urandom_range(0, 9) < 3;
            d_addr    = $urandom;
            d_wdata   = $urandom;
            mem_rdata = $urandom;
            #1;
            for (int l = 0; l < 3; l++) model_check(l, c);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
